// File: rtl/rl_pkg.sv
// Shared definitions for the RL action-selection slice: action encodings,
// grid/Q-table geometry, FSM state type and LFSR seed.
// Related build option: EPSILON_GREEDY_EN (see action_selector).
package rl_pkg;

   localparam int unsigned GRID_W      = 5;
   localparam int unsigned NUM_STATES  = 25;
   localparam int unsigned NUM_ACTIONS = 4;
   localparam int unsigned Q_W         = 16;
   localparam int unsigned Q_ADDR_W    = 7;
   localparam int unsigned STATE_W     = 6;
   localparam int unsigned ACT_W       = 4;
   localparam int unsigned LFSR_W      = 16;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [ACT_W-1:0] {
      ACT_RIGHT = 4'b0000,
      ACT_UP    = 4'b0001,
      ACT_LEFT  = 4'b0010,
      ACT_DOWN  = 4'b0011,
      ACT_NOP   = 4'b1111
   } action_e;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CMP,
      DONE
   } sel_state_e;

   // Grid states are 1-based; 0 and anything past the last cell are invalid.
   function automatic logic state_valid(input logic [STATE_W-1:0] s);
      return (s != '0) && (s <= STATE_W'(NUM_STATES));
   endfunction

   // First Q-table entry for a state: (s-1)*4.
   function automatic logic [Q_ADDR_W-1:0] q_base(input logic [STATE_W-1:0] s);
      logic [4:0] idx;
      idx = s[4:0] - 5'd1;
      return {idx, 2'b00};
   endfunction

endpackage

// File: rtl/action_selector_lfsr16.sv
// 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every
// cycle; reset loads the seed. Used only when EPSILON_GREEDY_EN is defined.
module lfsr16
   import rl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] value
);

   logic [LFSR_W-1:0] value_q;
   logic [LFSR_W-1:0] value_d;

   // Next state: shift left, feedback from taps 16,14,13,11.
   always_comb begin
      value_d = {value_q[14:0], value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10]};
   end

   // Register with synchronous seed load.
   always_ff @(posedge clk) begin
      if (rst) value_q <= seed;
      else     value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/action_selector.sv
// Action selector: reads the four Q-values of a grid state, picks the greedy
// action (ties to lowest index) and reports it with a one-cycle done pulse.
// Build option EPSILON_GREEDY_EN adds LFSR-driven epsilon-greedy exploration.
module action_selector
   import rl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [STATE_W-1:0]  state_in,
   input  logic [7:0]          epsilon,
   output logic                q_rd_en,
   output logic [Q_ADDR_W-1:0] q_addr,
   input  logic [Q_W-1:0]      q_rd_data,
   output logic                busy,
   output logic                done,
   output logic [ACT_W-1:0]    new_action,
   output logic [STATE_W-1:0]  current_state,
   output logic                explored,
   output logic                err
);

   sel_state_e          state_q, state_d;
   logic [1:0]          rd_cnt_q, rd_cnt_d;
   logic signed [Q_W-1:0] best_q, best_d;
   logic [1:0]          best_act_q, best_act_d;
   logic                q_rd_en_q, q_rd_en_d;
   logic [Q_ADDR_W-1:0] q_addr_q, q_addr_d;
   logic                done_q, done_d;
   logic [ACT_W-1:0]    new_action_q, new_action_d;
   logic [STATE_W-1:0]  current_state_q, current_state_d;
   logic                explored_q, explored_d;
   logic                err_q, err_d;
   logic                explore_q, explore_d;
   logic [1:0]          rand_act_q, rand_act_d;

   logic                explore_hit;
   logic [1:0]          rand_act;
   logic [1:0]          data_act;
   logic                take;

`ifdef EPSILON_GREEDY_EN
   logic [LFSR_W-1:0]   lfsr_value;
   logic                unused_lfsr_hi;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .seed  (LFSR_SEED),
      .value (lfsr_value)
   );

   assign explore_hit    = (lfsr_value[7:0] < epsilon);
   assign rand_act       = lfsr_value[9:8];
   assign unused_lfsr_hi = ^lfsr_value[15:10];
`else
   logic                unused_epsilon;

   // No exploration: explore_hit is constant 0, so explored_q never sets.
   assign explore_hit    = 1'b0;
   assign rand_act       = '0;
   assign unused_epsilon = ^epsilon;
`endif

   // Read data lags the strobe by one cycle: in READ it belongs to the
   // previous action, in CMP it is the last action's value.
   always_comb begin
      data_act = (state_q == CMP) ? 2'd3 : (rd_cnt_q - 2'd1);
      take     = (data_act == 2'd0) || ($signed(q_rd_data) > best_q);
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d         = state_q;
      rd_cnt_d        = rd_cnt_q;
      best_d          = best_q;
      best_act_d      = best_act_q;
      q_rd_en_d       = q_rd_en_q;
      q_addr_d        = q_addr_q;
      done_d          = 1'b0;
      new_action_d    = new_action_q;
      current_state_d = current_state_q;
      explored_d      = explored_q;
      err_d           = err_q;
      explore_d       = explore_q;
      rand_act_d      = rand_act_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               current_state_d = state_in;
               if (state_valid(state_in)) begin
                  state_d    = READ;
                  q_rd_en_d  = 1'b1;
                  q_addr_d   = q_base(state_in);
                  rd_cnt_d   = 2'd0;
                  explore_d  = explore_hit;
                  rand_act_d = rand_act;
               end else begin
                  done_d       = 1'b1;
                  new_action_d = ACT_NOP;
                  explored_d   = 1'b0;
                  err_d        = 1'b1;
               end
            end
         end
         READ: begin
            if (rd_cnt_q != 2'd0 && take) begin
               best_d     = $signed(q_rd_data);
               best_act_d = data_act;
            end
            if (rd_cnt_q == 2'd3) begin
               q_rd_en_d = 1'b0;
               q_addr_d  = '0;
               state_d   = CMP;
            end else begin
               rd_cnt_d = rd_cnt_q + 2'd1;
               q_addr_d = q_addr_q + 7'd1;
            end
         end
         CMP: begin
            state_d    = DONE;
            done_d     = 1'b1;
            explored_d = explore_q;
            err_d      = 1'b0;
            if (explore_q)  new_action_d = {2'b00, rand_act_q};
            else if (take)  new_action_d = {2'b00, data_act};
            else            new_action_d = {2'b00, best_act_q};
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         rd_cnt_q        <= '0;
         best_q          <= '0;
         best_act_q      <= '0;
         q_rd_en_q       <= 1'b0;
         q_addr_q        <= '0;
         done_q          <= 1'b0;
         new_action_q    <= ACT_NOP;
         current_state_q <= '0;
         explored_q      <= 1'b0;
         err_q           <= 1'b0;
         explore_q       <= 1'b0;
         rand_act_q      <= '0;
      end else begin
         state_q         <= state_d;
         rd_cnt_q        <= rd_cnt_d;
         best_q          <= best_d;
         best_act_q      <= best_act_d;
         q_rd_en_q       <= q_rd_en_d;
         q_addr_q        <= q_addr_d;
         done_q          <= done_d;
         new_action_q    <= new_action_d;
         current_state_q <= current_state_d;
         explored_q      <= explored_d;
         err_q           <= err_d;
         explore_q       <= explore_d;
         rand_act_q      <= rand_act_d;
      end
   end

   assign q_rd_en       = q_rd_en_q;
   assign q_addr        = q_addr_q;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign new_action    = new_action_q;
   assign current_state = current_state_q;
   assign explored      = explored_q;
   assign err           = err_q;

endmodule

// File: doc/action_selector.md
ACTION_SELECTOR -- requirements
Module: action_selector

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request one action decision; honoured only in IDLE.
REQ-005 state_in  input  6  current grid state, valid 1..25 (5x5 grid, row-major), sampled with start.
REQ-006 epsilon  input  8  exploration threshold, sampled with start.
REQ-007 q_rd_en  output  1  Q-table read strobe.
REQ-008 q_addr  output  7  Q-table address = (state-1)*4 + action.
REQ-009 q_rd_data  input  16  signed Q-value, valid exactly one cycle after q_rd_en.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 done  output  1  one-cycle pulse; new_action, current_state, explored, err valid in that cycle and held until the next start.
REQ-012 new_action  output  4  0000 right, 0001 up, 0010 left, 0011 down, 1111 no-move; feeds the state selector.
REQ-013 current_state  output  6  captured state_in, forwarded to the state selector alongside new_action.
REQ-014 explored  output  1  1 = action chosen randomly.
REQ-015 err  output  1  1 = state_in was out of range.

Function
REQ-016 FSM states SHALL be IDLE, READ, CMP, DONE; transitions IDLE->READ on start with valid state, READ->CMP after 4 cycles, CMP->DONE, DONE->IDLE.
REQ-017 start in cycle 0 SHALL give q_rd_en high in cycles 1-4 with actions 0,1,2,3 in order, q_rd_data consumed in cycles 2-5, and done high in cycle 6.
REQ-018 Greedy choice SHALL be the action with the largest signed q_rd_data; replacement only on strictly greater, so ties resolve to the lowest action index.
REQ-019 start while busy SHALL be ignored, with no effect on the decision in progress.
REQ-020 state_in of 0 or 26..63 SHALL skip all reads, pulse done in cycle 1, and set new_action=1111, err=1, explored=0.
REQ-021 q_addr SHALL be 0 whenever q_rd_en is low.

Reset
REQ-022 rst SHALL force IDLE and new_action=1111, current_state=0, done=0, busy=0, q_rd_en=0, q_addr=0, explored=0, err=0.
REQ-023 rst during READ or CMP SHALL abort the decision with no done pulse and no further reads.
REQ-024 rst SHALL reload the LFSR with 16'hACE1.

Configuration
REQ-025 Macro EPSILON_GREEDY_EN defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle.
REQ-026 In the start cycle, if lfsr[7:0] < epsilon, the decision SHALL be marked explored and the action set to lfsr[9:8].
REQ-027 Exploring decisions SHALL still perform all four reads, so latency is unchanged, with the result replaced by the random action and explored=1.
REQ-028 Macro EPSILON_GREEDY_EN undefined: no LFSR SHALL be built, epsilon SHALL be ignored, and explored SHALL be tied to 0.

Structure
REQ-029 Shared package rl_pkg SHALL hold: action encodings including NOP=1111, GRID_W=5, NUM_STATES=25, NUM_ACTIONS=4, Q_W=16, Q_ADDR_W=7, the FSM state typedef, and LFSR_SEED.
REQ-030 The LFSR SHALL be a sub-module lfsr16 (ports clk, rst, seed, value), instantiated only under EPSILON_GREEDY_EN.

Verification
REQ-031 state 7, Q-values {10,-3,42,5}, macro off -> reads at addresses 24..27 in cycles 1-4; done in cycle 6; new_action=0010; current_state=7.
REQ-032 state 1, Q-values {8,8,-1,8} -> new_action=0000 (tie resolves to lowest index).
REQ-033 state 0, then state 26 -> done in cycle 1, no q_rd_en, new_action=1111, err=1.
REQ-034 start re-asserted in cycles 2-5 of a decision -> ignored; exactly one done, in cycle 6.
REQ-035 rst asserted in cycle 3 of a decision -> all outputs at reset values in the next cycle, no done; a following start completes normally.
REQ-036 macro on, epsilon=255 versus epsilon=0 over 1000 decisions -> explored rate at least 99% versus 0%; each explored action equals lfsr[9:8] from a reference model seeded with ACE1.
